// File: rtl/adc_serial_capture.sv
// Serial ADC front end: drives CS and the sampling clock, captures one
// word per channel per frame, with a one-cycle valid strobe.
//
// Ports:
//   Clock_Nexys    system clock (rising edge)
//   Reset          synchronous, active-high
//   start          level; frames run back-to-back while high
//   data_ADC       serial data, bit c = channel c
//   CS             ADC chip select, active-low
//   Clock_Muestreo ADC sampling clock, idles high
//   sample         captured words, channel c at [c*DATA_W +: DATA_W]
//   sample_valid   one-cycle strobe when sample updates
//   lead_err       a leading bit was 1 in the delivered frame
//   busy           high while converting or in the quiet gap
//
// Optional: define ADC_LEAD_CHECK_EN to build the leading-bit check;
// otherwise lead_err is tied low and the leading bits are discarded.

module adc_serial_capture #(
  parameter int unsigned DATA_W    = 12,
  parameter int unsigned LEAD_W    = 4,
  parameter int unsigned CHANNELS  = 1,
  parameter int unsigned CLK_DIV   = 2,
  parameter int unsigned QUIET_CYC = 4
) (
  input  logic                       Clock_Nexys,
  input  logic                       Reset,
  input  logic                       start,
  input  logic [CHANNELS-1:0]        data_ADC,
  output logic                       CS,
  output logic                       Clock_Muestreo,
  output logic [CHANNELS*DATA_W-1:0] sample,
  output logic                       sample_valid,
  output logic                       lead_err,
  output logic                       busy
);

  localparam int unsigned NBITS = LEAD_W + DATA_W;
  localparam int unsigned DIV_W =
    (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BIT_W = $clog2(NBITS + 1);
  localparam int unsigned QW =
    (QUIET_CYC > 1) ? $clog2(QUIET_CYC) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST =
    DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST =
    BIT_W'(NBITS - 1);
  localparam logic [QW-1:0] Q_LAST =
    QW'(QUIET_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONV,
    S_QUIET
  } state_e;

  state_e                          state_q, state_d;
  logic [DIV_W-1:0]                div_q, div_d;
  logic                            sclk_q, sclk_d;
  logic [BIT_W-1:0]                bit_q, bit_d;
  logic                            done_q, done_d;
  logic [QW-1:0]                   quiet_q, quiet_d;
  logic [CHANNELS-1:0][DATA_W-1:0] shreg_q, shreg_d;
  logic [CHANNELS*DATA_W-1:0]      sample_q, sample_d;
  logic                            valid_q, valid_d;

  logic sclk_rise;
  logic frame_go;

`ifdef ADC_LEAD_CHECK_EN
  localparam logic [BIT_W-1:0] LEAD_END = BIT_W'(LEAD_W);
  logic lacc_q, lacc_d;
  logic lerr_q, lerr_d;
`endif

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    sclk_d    = sclk_q;
    bit_d     = bit_q;
    done_d    = done_q;
    quiet_d   = quiet_q;
    shreg_d   = shreg_q;
    sample_d  = sample_q;
    valid_d   = 1'b0;
    sclk_rise = 1'b0;
    frame_go  = 1'b0;
`ifdef ADC_LEAD_CHECK_EN
    lacc_d    = lacc_q;
    lerr_d    = 1'b0;
`endif

    unique case (state_q)
      S_IDLE: begin
        sclk_d   = 1'b1;
        frame_go = start;
      end

      S_CONV: begin
        if (done_q) begin
          // Last rising edge was one cycle ago: deliver and release CS.
          state_d  = S_QUIET;
          quiet_d  = '0;
          sclk_d   = 1'b1;
          sample_d = shreg_q;
          valid_d  = 1'b1;
`ifdef ADC_LEAD_CHECK_EN
          lerr_d   = lacc_q;
`endif
        end else if (div_q == DIV_LAST) begin
          div_d     = '0;
          sclk_d    = ~sclk_q;
          sclk_rise = ~sclk_q;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end

      S_QUIET: begin
        sclk_d = 1'b1;
        if (quiet_q == Q_LAST) begin
          if (start) begin
            frame_go = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          quiet_d = quiet_q + QW'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Leading bits fall off the top of the DATA_W-wide shift register.
    if (sclk_rise) begin
      for (int c = 0; c < int'(CHANNELS); c++) begin
        shreg_d[c] = (shreg_q[c] << 1) | DATA_W'(data_ADC[c]);
      end
      bit_d  = bit_q + BIT_W'(1);
      done_d = (bit_q == BIT_LAST);
`ifdef ADC_LEAD_CHECK_EN
      if (bit_q < LEAD_END) begin
        lacc_d = lacc_q | (|data_ADC);
      end
`endif
    end

    if (frame_go) begin
      state_d = S_CONV;
      div_d   = '0;
      bit_d   = '0;
      done_d  = 1'b0;
`ifdef ADC_LEAD_CHECK_EN
      lacc_d  = 1'b0;
`endif
    end
  end

  always_ff @(posedge Clock_Nexys) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      div_q    <= '0;
      sclk_q   <= 1'b1;
      bit_q    <= '0;
      done_q   <= 1'b0;
      quiet_q  <= '0;
      shreg_q  <= '0;
      sample_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      sclk_q   <= sclk_d;
      bit_q    <= bit_d;
      done_q   <= done_d;
      quiet_q  <= quiet_d;
      shreg_q  <= shreg_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
    end
  end

`ifdef ADC_LEAD_CHECK_EN
  always_ff @(posedge Clock_Nexys) begin
    if (Reset) begin
      lacc_q <= 1'b0;
      lerr_q <= 1'b0;
    end else begin
      lacc_q <= lacc_d;
      lerr_q <= lerr_d;
    end
  end

  assign lead_err = lerr_q;
`else
  assign lead_err = 1'b0;
`endif

  assign CS             = (state_q != S_CONV);
  assign Clock_Muestreo = sclk_q;
  assign busy           = (state_q != S_IDLE);
  assign sample         = sample_q;
  assign sample_valid   = valid_q;

endmodule

// File: tb/tb_adc_serial_capture.sv
// Scoreboard bench for adc_serial_capture: an ADC model shifts queued
// frames out on sclk falls; expected words are popped on each strobe.

module tb_adc_serial_capture;

  localparam int DW   = 12;
  localparam int LW   = 4;
  localparam int NB   = DW + LW;
  localparam int DIV  = 2;
  localparam int QC   = 4;
  localparam int LAT  = 2 * DIV * NB + 1;
  localparam int PER  = LAT + QC;
`ifdef ADC_LEAD_CHECK_EN
  localparam logic LCHK = 1'b1;
`else
  localparam logic LCHK = 1'b0;
`endif

  typedef struct {
    logic [DW-1:0] d;
    logic          le;
  } exp_t;

  logic clk;
  logic rst;
  logic start;
  logic [0:0] adc_d;
  logic cs, sclk, vld, lerr, busy;
  logic [DW-1:0] smp;

  logic start2;
  logic [1:0] adc_d2;
  logic cs2, sclk2, vld2, lerr2, busy2;
  logic [2*DW-1:0] smp2;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int nstrobe = 0;

  logic [NB-1:0] tx_q[$];
  exp_t          exp_q[$];
  logic [NB-1:0] tx2_q[$];
  logic [2*DW-1:0] exp2_q[$];

  adc_serial_capture #(
    .DATA_W(DW), .LEAD_W(LW), .CHANNELS(1),
    .CLK_DIV(DIV), .QUIET_CYC(QC)
  ) u_dut (
    .Clock_Nexys(clk), .Reset(rst), .start(start),
    .data_ADC(adc_d), .CS(cs), .Clock_Muestreo(sclk),
    .sample(smp), .sample_valid(vld),
    .lead_err(lerr), .busy(busy)
  );

  adc_serial_capture #(
    .DATA_W(DW), .LEAD_W(LW), .CHANNELS(2),
    .CLK_DIV(DIV), .QUIET_CYC(QC)
  ) u_dut2 (
    .Clock_Nexys(clk), .Reset(rst), .start(start2),
    .data_ADC(adc_d2), .CS(cs2), .Clock_Muestreo(sclk2),
    .sample(smp2), .sample_valid(vld2),
    .lead_err(lerr2), .busy(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, want);
  endtask

  // ADC models: load a frame on CS fall, drive next bit on sclk fall.
  logic [NB-1:0] fr;
  int idx = 0;
  logic cs_a = 1'b1, sc_a = 1'b1;
  always @(negedge clk) begin
    if (cs_a && !cs) begin
      fr  = (tx_q.size() != 0) ? tx_q.pop_front() : '0;
      idx = NB - 1;
    end
    if (sc_a && !sclk && !cs) begin
      adc_d[0] = fr[idx];
      if (idx > 0) idx--;
    end
    cs_a = cs;
    sc_a = sclk;
  end

  logic [NB-1:0] fr0, fr1;
  int idx2 = 0;
  logic cs_b = 1'b1, sc_b = 1'b1;
  always @(negedge clk) begin
    if (cs_b && !cs2) begin
      fr0  = (tx2_q.size() != 0) ? tx2_q.pop_front() : '0;
      fr1  = (tx2_q.size() != 0) ? tx2_q.pop_front() : '0;
      idx2 = NB - 1;
    end
    if (sc_b && !sclk2 && !cs2) begin
      adc_d2 = {fr1[idx2], fr0[idx2]};
      if (idx2 > 0) idx2--;
    end
    cs_b = cs2;
    sc_b = sclk2;
  end

  // Scoreboard / timing monitor
  logic cs_m = 1'b1;
  int cs_fall = 0;
  int hi_run = 0;
  int last_s = 0;
  bit held = 0;
  bit aft = 0;
  always @(negedge clk) begin
    exp_t e;
    if (cs_m && !cs) begin
      cs_fall = cyc;
      if (held && aft) chk("quiet_len", hi_run, QC);
      aft = 0;
    end
    hi_run = cs ? hi_run + 1 : 0;
    if (vld) begin
      nstrobe++;
      if (exp_q.size() == 0) begin
        chk("spurious_valid", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("sample", smp, e.d);
        chk("lead_err", lerr, e.le);
        chk("latency", cyc - cs_fall, LAT);
      end
      if (held) begin
        if (last_s != 0) chk("period", cyc - last_s, PER);
        last_s = cyc;
        aft = 1;
      end
    end
    cs_m = cs;
  end

  always @(negedge clk) begin
    if (vld2) begin
      if (exp2_q.size() == 0) chk("spurious_valid2", 1, 0);
      else chk("sample2", smp2, exp2_q.pop_front());
    end
  end

  task automatic push(input logic [NB-1:0] f, input logic le);
    exp_t e;
    tx_q.push_back(f);
    e.d  = f[DW-1:0];
    e.le = le;
    exp_q.push_back(e);
  endtask

  task automatic wait_valid();
    int i;
    i = 0;
    do begin
      @(negedge clk);
      i++;
    end while (!vld && i < 400);
    if (!vld) chk("valid_timeout", 0, 1);
  endtask

  // Called on the strobe cycle: check return to idle after the gap.
  task automatic tail_idle();
    @(negedge clk);
    chk("valid_one_cycle", vld, 0);
    chk("lead_err_low", lerr, 0);
    chk("cs_quiet", cs, 1);
    repeat (QC - 2) @(negedge clk);
    chk("busy_last_quiet", busy, 1);
    @(negedge clk);
    chk("busy_idle", busy, 0);
    chk("cs_idle", cs, 1);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_rises(input int n);
    int r, i;
    logic sp;
    r  = 0;
    i  = 0;
    sp = sclk;
    while (r < n && i < 400) begin
      @(negedge clk);
      if (!sp && sclk) r++;
      sp = sclk;
      i++;
    end
    if (r < n) chk("rise_timeout", r, n);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int ns;
    rst    = 1'b1;
    start  = 1'b0;
    start2 = 1'b0;
    adc_d  = '0;
    adc_d2 = '0;
    repeat (3) @(negedge clk);
    chk("rst_cs", cs, 1);
    chk("rst_sclk", sclk, 1);
    chk("rst_sample", smp, 0);
    chk("rst_valid", vld, 0);
    chk("rst_lead_err", lerr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sample2", smp2, 0);
    rst = 1'b0;

    // Single frame A5C, pulsed start
    push({4'b0000, 12'hA5C}, 1'b0);
    pulse_start();
    chk("cs_fall", cs, 0);
    chk("busy_conv", busy, 1);
    chk("sclk_at_cs_fall", sclk, 1);
    repeat (DIV - 1) @(negedge clk);
    chk("sclk_pre_fall", sclk, 1);
    @(negedge clk);
    chk("sclk_first_fall", sclk, 0);
    wait_valid();
    tail_idle();

    // Back-to-back frames with start held
    held   = 1;
    last_s = 0;
    push({4'b0000, 12'h000}, 1'b0);
    push({4'b0000, 12'hFFF}, 1'b0);
    push({4'b0000, 12'h800}, 1'b0);
    @(negedge clk);
    start = 1'b1;
    wait_valid();
    wait_valid();
    wait_valid();
    start = 1'b0;
    tail_idle();
    held = 0;
    aft  = 0;

    // Leading-bit check, then a clean frame
    push({4'b0100, 12'h055}, LCHK);
    pulse_start();
    wait_valid();
    tail_idle();
    push({4'b0000, 12'h3C3}, 1'b0);
    pulse_start();
    wait_valid();
    tail_idle();

    // Reset at the 8th sclk rise: frame discarded
    tx_q.push_back({4'b0000, 12'h777});
    ns = nstrobe;
    pulse_start();
    wait_rises(8);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_cs", cs, 1);
    chk("mid_rst_sclk", sclk, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_valid", vld, 0);
    chk("mid_rst_sample", smp, 0);
    rst = 1'b0;
    repeat (150) @(negedge clk);
    chk("mid_rst_no_strobe", nstrobe, ns);
    chk("mid_rst_cs_idle", cs, 1);

    // start dropped after 3rd sclk rise
    push({4'b0000, 12'h5A3}, 1'b0);
    ns = nstrobe;
    @(negedge clk);
    start = 1'b1;
    wait_rises(3);
    start = 1'b0;
    wait_valid();
    tail_idle();
    repeat (100) @(negedge clk);
    chk("drop_one_strobe", nstrobe, ns + 1);
    chk("drop_cs_idle", cs, 1);

    // Two channels sharing CS/sclk
    tx2_q.push_back({4'b0000, 12'h123});
    tx2_q.push_back({4'b0000, 12'hABC});
    exp2_q.push_back(24'hABC123);
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    begin
      int i;
      i = 0;
      do begin
        @(negedge clk);
        i++;
      end while (!vld2 && i < 400);
      if (!vld2) chk("valid2_timeout", 0, 1);
    end
    repeat (10) @(negedge clk);
    chk("lead_err2_low", lerr2, 0);
    chk("busy2_idle", busy2, 0);

    chk("exp_q_empty", exp_q.size(), 0);
    chk("exp2_q_empty", exp2_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
